// File: rtl/cordic_polar_post_if.sv
// Sample/result handshake bundle between upstream, cordic_polar_post and downstream.
// The slave modport is the post-processor's view; master is the surrounding system's view.
interface cordic_polar_post_if #(
    parameter int WIDTH            = 16,
    parameter int EXTEND_PRECISION = 4,
    parameter int AWIDTH           = 16
);
    logic                              in_valid;
    logic                              in_mirror;
    logic                              in_ready;
    logic                              out_valid;
    logic                              out_ready;
    logic [WIDTH+EXTEND_PRECISION-1:0] out_mag;
    logic [AWIDTH-1:0]                 out_ang;

    modport master (
        output in_valid, in_mirror, out_ready,
        input  in_ready, out_valid, out_mag, out_ang
    );

    modport slave (
        input  in_valid, in_mirror, out_ready,
        output in_ready, out_valid, out_mag, out_ang
    );
endinterface

// File: rtl/cordic_polar_post.sv
// Post-processing for the rect-to-polar CORDIC core: tags samples through the core,
// removes the CORDIC gain, restores the full-circle angle and buffers results in a FIFO.
module cordic_polar_post #(
    parameter int PIPELINE         = 15,
    parameter int WIDTH            = 16,
    parameter int EXTEND_PRECISION = 4,
    parameter int AWIDTH           = 16,
    parameter int KGAIN            = 39797,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    cordic_polar_post_if.slave                bus,
    output logic                              ena,
    input  logic [WIDTH+EXTEND_PRECISION-1:0] r_in,
    input  logic [AWIDTH-1:0]                 a_in
);
    localparam int RW   = WIDTH + EXTEND_PRECISION;
    localparam int PW   = RW + 16;
    localparam int EW   = RW + AWIDTH;
    localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = PTRW + 1;
    localparam logic [AWIDTH-1:0] HALF = AWIDTH'(1) << (AWIDTH - 1);
    localparam logic [PW-1:0]     RND  = PW'(1) << 15;

    logic [PIPELINE-1:0] tag_v;
    logic [PIPELINE-1:0] tag_m;
    logic                p1_v;
    logic [PW-1:0]       p1_prod;
    logic [AWIDTH-1:0]   p1_ang;
    logic                p2_v;
    logic [RW-1:0]       p2_mag;
    logic [AWIDTH-1:0]   p2_ang;

    logic [EW-1:0]       mem [FIFO_DEPTH];
    logic [PTRW-1:0]     wr_ptr;
    logic [PTRW-1:0]     rd_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       remain;
    logic [EW-1:0]       head_q;
    logic [EW-1:0]       head_n;
    logic [EW-1:0]       push_data;
    logic                out_valid;
    logic                full;
    logic                push;
    logic                pop;

    // A full FIFO stalls the core and this pipeline unless the head leaves this cycle.
    assign out_valid = (count != '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = out_valid && bus.out_ready;
    assign ena       = !full || pop;
    assign push      = ena && p2_v;
    assign push_data = {p2_mag, p2_ang};

    assign bus.in_ready  = ena;
    assign bus.out_valid = out_valid;
    assign bus.out_mag   = head_q[EW-1:AWIDTH];
    assign bus.out_ang   = head_q[AWIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v <= '0;
            p1_v  <= 1'b0;
            p2_v  <= 1'b0;
        end else if (ena) begin
            tag_v <= {tag_v[PIPELINE-2:0], bus.in_valid};
            p1_v  <= tag_v[PIPELINE-1];
            p2_v  <= p1_v;
        end
    end

    // Data side is never reset; stale core data is discarded through the valid bits.
    always_ff @(posedge clk) begin
        if (ena) begin
            tag_m   <= {tag_m[PIPELINE-2:0], bus.in_mirror};
            p1_prod <= PW'(r_in) * PW'(KGAIN);
            p1_ang  <= tag_m[PIPELINE-1] ? HALF - a_in : a_in;
            p2_mag  <= RW'((p1_prod + RND) >> 16);
            p2_ang  <= p1_ang;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The head register is loaded with whatever entry will be at the front after this edge.
    always_comb begin
        remain = count - CW'(pop);
        head_n = head_q;
        if (remain != '0) begin
            head_n = mem[rd_ptr + PTRW'(pop)];
        end else if (push) begin
            head_n = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            count  <= count + CW'(push) - CW'(pop);
            head_q <= head_n;
        end
    end
endmodule

// File: tb/tb_cordic_polar_post.sv
// Bench for cordic_polar_post: an ideal CORDIC core stub feeds r_in/a_in, and results
// are compared against an arithmetic model of the gain correction and angle unfolding.
module tb_cordic_polar_post;
    localparam int PIPELINE   = 15;
    localparam int WIDTH      = 16;
    localparam int EP         = 4;
    localparam int AWIDTH     = 16;
    localparam int KGAIN      = 39797;
    localparam int FIFO_DEPTH = 4;
    localparam int RW         = WIDTH + EP;
    localparam int LAT        = PIPELINE + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena;
    logic [RW-1:0] r_in;
    logic [15:0]   a_in;
    int            xi = 0;
    int            yi = 0;

    int pass_cnt = 0;
    int total    = 0;

    logic [35:0] exp_q[$];
    logic [35:0] obs_q[$];

    cordic_polar_post_if #(.WIDTH(WIDTH), .EXTEND_PRECISION(EP), .AWIDTH(AWIDTH)) bus();

    cordic_polar_post #(
        .PIPELINE(PIPELINE), .WIDTH(WIDTH), .EXTEND_PRECISION(EP),
        .AWIDTH(AWIDTH), .KGAIN(KGAIN), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .ena(ena), .r_in(r_in), .a_in(a_in)
    );

    always #5 clk = ~clk;

    // Ideal core outputs: magnitude carries the CORDIC gain and 4 extra fraction bits.
    function automatic logic [RW-1:0] stub_r(input int x, input int y);
        real v;
        v = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * 16.0 * 1.646760258;
        return RW'(longint'(v));
    endfunction

    function automatic logic [15:0] stub_a(input int x, input int y);
        real v;
        v = $atan2(real'(y), real'(x)) * 32768.0 / 3.141592653589793;
        return 16'(int'(v));
    endfunction

    function automatic logic [35:0] model(input int x, input int y, input bit m);
        longint r;
        longint mag;
        int     a;
        int     ang;
        r   = longint'(stub_r(x, y));
        mag = (r * KGAIN + 32768) / 65536;
        a   = int'(stub_a(x, y));
        ang = m ? ((32768 - a) % 65536 + 65536) % 65536 : a;
        return {20'(mag), 16'(ang)};
    endfunction

    logic [RW-1:0] core_r [PIPELINE];
    logic [15:0]   core_a [PIPELINE];
    always @(posedge clk) begin
        if (ena) begin
            core_r[0] <= stub_r(xi, yi);
            core_a[0] <= stub_a(xi, yi);
            for (int i = 1; i < PIPELINE; i++) begin
                core_r[i] <= core_r[i-1];
                core_a[i] <= core_a[i-1];
            end
        end
    end
    assign r_in = core_r[PIPELINE-1];
    assign a_in = core_a[PIPELINE-1];

    always @(negedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) exp_q.push_back(model(xi, yi, bus.in_mirror));
        if (!rst && bus.out_valid && bus.out_ready) obs_q.push_back({bus.out_mag, bus.out_ang});
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input int x, input int y, input bit m,
                            output logic [35:0] got, output int lat);
        xi = x; yi = y; bus.in_mirror = m; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        got = {bus.out_mag, bus.out_ang};
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_mirror = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); else pass_cnt++;
        total++; if (bus.out_mag !== '0) $display("FAIL reset_out_mag: got %0d want 0", bus.out_mag); else pass_cnt++;
        total++; if (bus.out_ang !== '0) $display("FAIL reset_out_ang: got %0h want 0", bus.out_ang); else pass_cnt++;
        rst = 1'b0;
        tick();
        total++; if (ena !== 1'b1) $display("FAIL reset_ena: got %0b want 1", ena); else pass_cnt++;
    endtask

    task automatic test_single();
        logic [35:0] got;
        int lat;
        int d;
        exp_q.delete(); obs_q.delete();
        send_one(16384, 0, 1'b0, got, lat);
        total++; if (lat != LAT) $display("FAIL single_latency: got %0d want %0d", lat, LAT); else pass_cnt++;
        total++; if (got !== model(16384, 0, 1'b0)) $display("FAIL single_value: got %h want %h", got, model(16384, 0, 1'b0)); else pass_cnt++;
        d = int'(got[35:16]) - 262144;
        total++; if (d < -4 || d > 4) $display("FAIL single_mag_tol: got %0d want 262144+-4", got[35:16]); else pass_cnt++;
        repeat (30) tick();
        total++; if (obs_q.size() != 1) $display("FAIL single_count: got %0d want 1", obs_q.size()); else pass_cnt++;
    endtask

    task automatic test_mirror_quadrants();
        int tx[5]   = '{10000, 10000, 16384, 10000, 10000};
        int ty[5]   = '{10000, 10000, 0, -10000, -10000};
        bit tm[5]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int tmag[5] = '{226274, 226274, 262144, 226274, 226274};
        int tang[5] = '{'h2000, 'h6000, 'h8000, 'hE000, 'hA000};
        int ttol[5] = '{2, 2, 0, 2, 2};
        logic [35:0] got;
        int lat;
        int d;
        for (int k = 0; k < 5; k++) begin
            send_one(tx[k], ty[k], tm[k], got, lat);
            repeat (3) tick();
            total++; if (got !== model(tx[k], ty[k], tm[k])) $display("FAIL quad%0d_value: got %h want %h", k, got, model(tx[k], ty[k], tm[k])); else pass_cnt++;
            d = int'(got[35:16]) - tmag[k];
            total++; if (d < -4 || d > 4) $display("FAIL quad%0d_mag_tol: got %0d want %0d+-4", k, got[35:16], tmag[k]); else pass_cnt++;
            d = int'(got[15:0]) - tang[k];
            d = ((d % 65536) + 65536 + 32768) % 65536 - 32768;
            total++; if (d < -ttol[k] || d > ttol[k]) $display("FAIL quad%0d_ang_tol: got %h want %h+-%0d", k, got[15:0], tang[k], ttol[k]); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int guard = 0;
        logic acc;
        logic [35:0] head;
        exp_q.delete(); obs_q.delete();
        bus.out_ready = 1'b0;
        while (sent < 20 && guard < 200) begin
            xi = $urandom_range(0, 20000); yi = int'($urandom_range(0, 40000)) - 20000;
            bus.in_mirror = 1'($urandom_range(0, 1)); bus.in_valid = 1'b1;
            do begin
                @(negedge clk); acc = bus.in_ready; tick(); guard++;
            end while (!acc && guard < 200);
            if (acc) sent++;
        end
        bus.in_valid = 1'b0;
        repeat (40) tick();
        total++; if (sent != 20) $display("FAIL bp_sent: got %0d want 20", sent); else pass_cnt++;
        total++; if (ena !== 1'b0) $display("FAIL bp_frozen_ena: got %0b want 0", ena); else pass_cnt++;
        total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid: got %0b want 1", bus.out_valid); else pass_cnt++;
        total++; if (exp_q.size() != 20) $display("FAIL bp_accepted: got %0d want 20", exp_q.size()); else pass_cnt++;
        head = {bus.out_mag, bus.out_ang};
        total++; if (head !== exp_q[0]) $display("FAIL bp_head: got %h want %h", head, exp_q[0]); else pass_cnt++;
        repeat (10) tick();
        total++; if ({bus.out_mag, bus.out_ang} !== exp_q[0]) $display("FAIL bp_head_stable: got %h want %h", {bus.out_mag, bus.out_ang}, exp_q[0]); else pass_cnt++;
        bus.out_ready = 1'b1;
        #1;
        total++; if (ena !== 1'b1) $display("FAIL bp_pop_ena: got %0b want 1", ena); else pass_cnt++;
        guard = 0;
        while (obs_q.size() < 20 && guard < 200) begin tick(); guard++; end
        repeat (10) tick();
        total++; if (obs_q.size() != 20) $display("FAIL bp_out_count: got %0d want 20", obs_q.size()); else pass_cnt++;
        for (int k = 0; k < 20 && k < obs_q.size(); k++) begin
            total++; if (obs_q[k] !== exp_q[k]) $display("FAIL bp_order%0d: got %h want %h", k, obs_q[k], exp_q[k]); else pass_cnt++;
        end
    endtask

    task automatic test_bubbles_random();
        int guard = 0;
        logic acc;
        exp_q.delete(); obs_q.delete();
        for (int k = 0; k < 40; k++) begin
            xi = $urandom_range(0, 20000); yi = int'($urandom_range(0, 40000)) - 20000;
            bus.in_mirror = 1'($urandom_range(0, 1));
            bus.in_valid = (k % 2 == 0);
            do begin
                bus.out_ready = 1'($urandom_range(0, 1));
                @(negedge clk); acc = bus.in_ready; tick(); guard++;
            end while (!acc && guard < 1000);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (40) tick();
        total++; if (exp_q.size() != 20) $display("FAIL rnd_accepted: got %0d want 20", exp_q.size()); else pass_cnt++;
        total++; if (obs_q.size() != exp_q.size()) $display("FAIL rnd_out_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            total++; if (obs_q[k] !== exp_q[k]) $display("FAIL rnd_order%0d: got %h want %h", k, obs_q[k], exp_q[k]); else pass_cnt++;
        end
    endtask

    task automatic test_reset_midstream();
        logic [35:0] got;
        int lat;
        int x;
        int y;
        exp_q.delete(); obs_q.delete();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            xi = $urandom_range(0, 20000); yi = int'($urandom_range(0, 40000)) - 20000;
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (7) tick();
        total++; if (bus.out_valid !== 1'b1) $display("FAIL mid_buffered: got %0b want 1", bus.out_valid); else pass_cnt++;
        rst = 1'b1;
        tick();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_out_valid: got %0b want 0", bus.out_valid); else pass_cnt++;
        total++; if (bus.out_mag !== '0) $display("FAIL mid_out_mag: got %0d want 0", bus.out_mag); else pass_cnt++;
        total++; if (bus.out_ang !== '0) $display("FAIL mid_out_ang: got %h want 0", bus.out_ang); else pass_cnt++;
        total++; if (ena !== 1'b1) $display("FAIL mid_ena: got %0b want 1", ena); else pass_cnt++;
        rst = 1'b0;
        exp_q.delete(); obs_q.delete();
        bus.out_ready = 1'b1;
        repeat (40) tick();
        total++; if (obs_q.size() != 0) $display("FAIL mid_stale: got %0d outputs want 0", obs_q.size()); else pass_cnt++;
        x = $urandom_range(0, 20000); y = int'($urandom_range(0, 40000)) - 20000;
        send_one(x, y, 1'b1, got, lat);
        repeat (5) tick();
        total++; if (lat != LAT) $display("FAIL mid_latency: got %0d want %0d", lat, LAT); else pass_cnt++;
        total++; if (got !== model(x, y, 1'b1)) $display("FAIL mid_value: got %h want %h", got, model(x, y, 1'b1)); else pass_cnt++;
        total++; if (obs_q.size() != 1) $display("FAIL mid_count: got %0d want 1", obs_q.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_mirror_quadrants();
        test_backpressure();
        test_bubbles_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
